// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 pipeline definitions.
//   icode constants, ALU function codes, branch/cmov condition codes,
//   the "no register" ID and the condition-code record.
package y86_pkg;

    // Instruction codes seen by the execute stage
    localparam logic [3:0] I_RRMOVQ = 4'h2;  // rrmovq / cmovXX
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;

    // ALU function codes (ifun of OPq)
    localparam logic [3:0] ADD = 4'h0;
    localparam logic [3:0] SUB = 4'h1;   // B - A
    localparam logic [3:0] AND = 4'h2;
    localparam logic [3:0] XOR = 4'h3;

    // Condition codes (ifun of jXX / cmovXX)
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Register ID meaning "no destination"
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

endpackage

// File: rtl/exec_cc_stage_cond_eval.sv
// cond_eval: combinational Y86 condition evaluation for jXX / cmovXX.
// Ports:
//   zf, sf, of : condition codes to test
//   ifun       : condition selector (C_* in y86_pkg)
//   cnd        : 1 when the condition holds; 0 for undefined selectors
module cond_eval
    import y86_pkg::*;
(
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic lt;

    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES: cnd = 1'b1;
            C_LE:  cnd = lt | zf;
            C_L:   cnd = lt;
            C_E:   cnd = zf;
            C_NE:  cnd = ~zf;
            C_GE:  cnd = ~lt;
            C_G:   cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cc_stage.sv
// exec_cc_stage: Y86 execute-stage back end.
//   Captures the ALU result into the E->M register, maintains the
//   condition-code register (ZF/SF/OF) and evaluates Cnd for jXX/cmovXX.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : upstream handshake (in_ready combinational)
//   in_icode, in_ifun     : instruction and function codes
//   in_alu_a/b/result     : ALU operands and result
//   in_dstE               : destination for valE
//   cc_inhibit            : block CC update (later-stage exception)
//   flush                 : squash the output register at the edge
//   out_valid / out_ready : downstream handshake
//   out_icode/valE/dstE/cnd : registered E->M payload
//   cc_zf, cc_sf, cc_of   : current condition codes
module exec_cc_stage
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter logic [3:0]  RNONE = y86_pkg::RNONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_icode,
    input  logic [3:0]       in_ifun,
    input  logic [WIDTH-1:0] in_alu_a,
    input  logic [WIDTH-1:0] in_alu_b,
    input  logic [WIDTH-1:0] in_alu_result,
    input  logic [3:0]       in_dstE,
    input  logic             cc_inhibit,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_icode,
    output logic [WIDTH-1:0] out_valE,
    output logic [3:0]       out_dstE,
    output logic             out_cnd,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    cc_t        cc_q;
    cc_t        cc_new;
    logic       accept;
    logic       cc_upd;
    logic       cnd;
    logic       cnd_d;
    logic [3:0] dste_d;
    logic       a_msb, b_msb, r_msb;

    // Only the sign bits of the operands feed the overflow logic.
    logic       unused_ok;
    assign unused_ok = ^{in_alu_a[WIDTH-2:0], in_alu_b[WIDTH-2:0]};

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    assign a_msb = in_alu_a[WIDTH-1];
    assign b_msb = in_alu_b[WIDTH-1];
    assign r_msb = in_alu_result[WIDTH-1];

    // Condition is tested against the CC held before this instruction.
    cond_eval u_cond_eval (
        .zf   (cc_q.zf),
        .sf   (cc_q.sf),
        .of   (cc_q.of),
        .ifun (in_ifun),
        .cnd  (cnd)
    );

    always_comb begin
        cnd_d  = 1'b0;
        dste_d = in_dstE;
        if (in_icode == I_RRMOVQ || in_icode == I_JXX) begin
            cnd_d = cnd;
        end
        if (in_icode == I_RRMOVQ && !cnd) begin
            dste_d = RNONE;
        end
    end

    // Undefined ALU functions leave the whole CC register untouched.
    always_comb begin
        cc_new    = cc_q;
        cc_new.zf = (in_alu_result == '0);
        cc_new.sf = r_msb;
        cc_upd    = accept && (in_icode == I_OPQ) && !cc_inhibit && !flush;
        case (in_ifun)
            ADD:      cc_new.of = (a_msb == b_msb) && (r_msb != a_msb);
            SUB:      cc_new.of = (a_msb != b_msb) && (r_msb != b_msb);
            AND, XOR: cc_new.of = 1'b0;
            default: begin
                cc_new = cc_q;
                cc_upd = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else if (cc_upd) begin
            cc_q <= cc_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_icode <= '0;
            out_valE  <= '0;
            out_dstE  <= RNONE;
            out_cnd   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_dstE  <= RNONE;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_icode <= in_icode;
            out_valE  <= in_alu_result;
            out_dstE  <= dste_d;
            out_cnd   <= cnd_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign cc_zf = cc_q.zf;
    assign cc_sf = cc_q.sf;
    assign cc_of = cc_q.of;

endmodule

// File: tb/tb_exec_cc_stage.sv
module tb_exec_cc_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode;
    logic [3:0]  in_ifun;
    logic [63:0] in_alu_a;
    logic [63:0] in_alu_b;
    logic [63:0] in_alu_result;
    logic [3:0]  in_dstE;
    logic        cc_inhibit;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [63:0] out_valE;
    logic [3:0]  out_dstE;
    logic        out_cnd;
    logic        cc_zf;
    logic        cc_sf;
    logic        cc_of;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // reference model state
    bit          m_zf, m_sf, m_of;
    bit          m_valid;
    logic [3:0]  m_icode;
    logic [63:0] m_valE;
    logic [3:0]  m_dstE;
    bit          m_cnd;

    exec_cc_stage #(.WIDTH(64), .RNONE(4'hF)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_icode      (in_icode),
        .in_ifun       (in_ifun),
        .in_alu_a      (in_alu_a),
        .in_alu_b      (in_alu_b),
        .in_alu_result (in_alu_result),
        .in_dstE       (in_dstE),
        .cc_inhibit    (cc_inhibit),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_icode     (out_icode),
        .out_valE      (out_valE),
        .out_dstE      (out_dstE),
        .out_cnd       (out_cnd),
        .cc_zf         (cc_zf),
        .cc_sf         (cc_sf),
        .cc_of         (cc_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] f, input bit zf, input bit sf, input bit of);
        bit less;
        less = (sf != of);
        case (f)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_zf = 1; m_sf = 0; m_of = 0;
        m_valid = 0; m_icode = 4'h0; m_valE = '0; m_dstE = 4'hF; m_cnd = 0;
    endtask

    // Apply one clock edge to the model using the inputs presented before it.
    task automatic model_edge();
        bit              acc, c;
        logic signed [64:0] sa, sb, wide;
        acc = in_valid && (!m_valid || out_ready);
        c   = cond_holds(in_ifun, m_zf, m_sf, m_of);
        if (flush) begin
            m_valid = 0;
            m_dstE  = 4'hF;
        end else if (acc) begin
            m_valid = 1;
            m_icode = in_icode;
            m_valE  = in_alu_result;
            m_cnd   = (in_icode == 4'd2 || in_icode == 4'd7) ? c : 1'b0;
            m_dstE  = (in_icode == 4'd2 && !c) ? 4'hF : in_dstE;
            if (in_icode == 4'd6 && !cc_inhibit && in_ifun <= 4'd3) begin
                sa = {in_alu_a[63], in_alu_a};
                sb = {in_alu_b[63], in_alu_b};
                m_zf = (in_alu_result == 64'd0);
                m_sf = $signed(in_alu_result) < 0;
                if (in_ifun == 4'd0) begin
                    wide = sb + sa;
                    m_of = wide != {in_alu_result[63], in_alu_result};
                end else if (in_ifun == 4'd1) begin
                    wide = sb - sa;
                    m_of = wide != {in_alu_result[63], in_alu_result};
                end else begin
                    m_of = 0;
                end
            end
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_outputs();
        check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        check("out_icode", {60'd0, out_icode}, {60'd0, m_icode});
        check("out_valE",  out_valE, m_valE);
        check("out_dstE",  {60'd0, out_dstE}, {60'd0, m_dstE});
        check("out_cnd",   {63'd0, out_cnd}, {63'd0, m_cnd});
        check("cc_zf",     {63'd0, cc_zf}, {63'd0, m_zf});
        check("cc_sf",     {63'd0, cc_sf}, {63'd0, m_sf});
        check("cc_of",     {63'd0, cc_of}, {63'd0, m_of});
    endtask

    task automatic drive(input bit v, input bit rdy, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] r,
                         input logic [3:0] d, input bit inh, input bit fl);
        in_valid = v; out_ready = rdy; in_icode = ic; in_ifun = fn;
        in_alu_a = a; in_alu_b = b; in_alu_result = r; in_dstE = d;
        cc_inhibit = inh; flush = fl;
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic step();
        #1;
        check("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    function automatic logic [63:0] alu(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        case (f)
            4'd0:    return b + a;
            4'd1:    return b - a;
            4'd2:    return b & a;
            default: return b ^ a;
        endcase
    endfunction

    task automatic rand_cycle();
        logic [3:0]  ic, fn;
        logic [63:0] a, b, r;
        int unsigned sel;
        sel = $urandom_range(0, 9);
        ic  = (sel < 4) ? 4'd6 : (sel < 6) ? 4'd7 : (sel < 8) ? 4'd2 : 4'($urandom_range(0, 15));
        fn  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
        a   = {$urandom, $urandom};
        b   = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
        if ($urandom_range(0, 5) == 0) begin
            a = 64'($urandom_range(0, 3)) << 62;
            b = 64'($urandom_range(0, 3)) << 62;
        end
        r = (ic == 4'd6 && fn <= 4'd3) ? alu(fn, a, b) : {$urandom, $urandom};
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ic, fn, a, b, r,
              4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        step();
    endtask

    initial begin
        drive(0, 1, 4'd0, 4'd0, '0, '0, '0, 4'd0, 0, 0);
        rst = 1'b1;
        model_reset();
        #12;
        check("reset zf", {63'd0, cc_zf}, 64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset out_dstE", {60'd0, out_dstE}, 64'hF);
        @(negedge clk);
        rst = 1'b0;
        compare_outputs();

        // sub overflow: 0x8000.. - 1
        drive(1, 1, 4'd6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 4'd1, 0, 0);
        step();
        check("subov of", {63'd0, cc_of}, 64'd1);
        check("subov sf", {63'd0, cc_sf}, 64'd0);
        check("subov zf", {63'd0, cc_zf}, 64'd0);

        // compare equal then branch
        drive(1, 1, 4'd6, 4'd1, 64'd5, 64'd5, 64'd0, 4'd2, 0, 0);
        step();
        check("cmp zf", {63'd0, cc_zf}, 64'd1);
        drive(1, 1, 4'd7, 4'd3, 64'd0, 64'd0, 64'h100, 4'hF, 0, 0);
        step();
        check("je cnd", {63'd0, out_cnd}, 64'd1);
        drive(1, 1, 4'd7, 4'd4, 64'd0, 64'd0, 64'h100, 4'hF, 0, 0);
        step();
        check("jne cnd", {63'd0, out_cnd}, 64'd0);

        // cmovl not taken with SF=OF=0
        drive(1, 1, 4'd2, 4'd2, 64'h1234, 64'd0, 64'h1234, 4'd3, 0, 0);
        step();
        check("cmov dstE", {60'd0, out_dstE}, 64'hF);
        check("cmov valE", out_valE, 64'h1234);

        // backpressure: accept add 2+3, then stall three cycles
        drive(1, 1, 4'd6, 4'd0, 64'd2, 64'd3, 64'd5, 4'd4, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 4'd6, 4'd1, 64'd9, 64'd9, 64'd0, 4'd5, 0, 0);
            step();
            check("bp in_ready", {63'd0, in_ready}, 64'd0);
            check("bp valE", out_valE, 64'd5);
            check("bp zf", {63'd0, cc_zf}, 64'd0);
        end
        drive(1, 1, 4'd6, 4'd1, 64'd9, 64'd9, 64'd0, 4'd5, 0, 0);
        step();
        check("bp release valE", out_valE, 64'd0);
        check("bp release zf", {63'd0, cc_zf}, 64'd1);

        // flush wins over an accepted OPq
        drive(1, 1, 4'd6, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd6, 0, 1);
        step();
        check("flush valid", {63'd0, out_valid}, 64'd0);
        check("flush sf", {63'd0, cc_sf}, 64'd0);
        check("flush dstE", {60'd0, out_dstE}, 64'hF);

        // inhibit: set ZF=0 first, then an inhibited zero result
        drive(1, 1, 4'd6, 4'd0, 64'd1, 64'd1, 64'd2, 4'd7, 0, 0);
        step();
        drive(1, 1, 4'd6, 4'd1, 64'd7, 64'd7, 64'd0, 4'd7, 1, 0);
        step();
        check("inhibit zf", {63'd0, cc_zf}, 64'd0);

        for (int i = 0; i < 3000; i++) rand_cycle();

        // asynchronous reset in the middle of the low phase
        drive(1, 0, 4'd6, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 0, 0);
        step();
        drive(0, 0, 4'd0, 4'd0, '0, '0, '0, 4'd0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async rst zf", {63'd0, cc_zf}, 64'd1);
        check("async rst sf", {63'd0, cc_sf}, 64'd0);
        check("async rst of", {63'd0, cc_of}, 64'd0);
        check("async rst valid", {63'd0, out_valid}, 64'd0);
        check("async rst dstE", {60'd0, out_dstE}, 64'hF);
        #1;
        rst = 1'b0;
        @(negedge clk);
        compare_outputs();

        for (int i = 0; i < 500; i++) rand_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_cc_stage.md
Name: exec_cc_stage

Overview:
- Sits directly downstream of the 64-bit ALU (add/sub/and/xor datapath) in the execute stage of the Y86 pipeline.
- Captures the ALU result and derives ZF/SF/OF from it, holding them in the condition-code register.
- Evaluates Cnd for jXX/cmovXX and presents a registered E->M payload through a valid/ready handshake with flush.

Parameters:
- WIDTH, 64, datapath width of operands and result.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  execute payload valid
- in_ready  output  1  stage can accept payload
- in_icode  input  4  instruction code (2 = rrmovq/cmovXX, 6 = OPq, 7 = jXX)
- in_ifun  input  4  function code (ALU op for OPq; condition for jXX/cmovXX)
- in_alu_a  input  WIDTH  ALU operand A (valA/valC)
- in_alu_b  input  WIDTH  ALU operand B (valB)
- in_alu_result  input  WIDTH  ALU output (B+A, B-A, B&A, B^A)
- in_dstE  input  4  destination register for valE
- cc_inhibit  input  1  suppress CC update (exception in a later stage)
- flush  input  1  synchronous squash of the output register
- out_valid  output  1  E->M payload valid
- out_ready  input  1  downstream accepts payload
- out_icode  output  4  registered icode
- out_valE  output  WIDTH  registered ALU result
- out_dstE  output  4  registered dstE, RNONE when cmov is not taken
- out_cnd  output  1  registered condition result
- cc_zf, cc_sf, cc_of  output  1 each  current condition codes

Behaviour:
- Reset (asynchronous, rst=1): out_valid=0; out_icode=0; out_valE=0; out_dstE=RNONE; out_cnd=0; ZF=1, SF=0, OF=0.
- Handshake:
  - in_ready = !out_valid || out_ready, purely combinational.
  - Accept = in_valid && in_ready.
  - On accept, the output register loads at the next edge, so latency is 1 cycle.
  - If out_valid && !out_ready, all outputs hold and in_ready=0.
  - If out_ready && !accept, out_valid falls to 0.
- Flush:
  - At the edge, out_valid is cleared and out_dstE is set to RNONE.
  - A flush has priority over a simultaneous accept: the payload is dropped and CC is not updated.
- CC update occurs on an edge with accept && in_icode==6 && !cc_inhibit && !flush:
  - ZF = (result == 0).
  - SF = result[WIDTH-1].
  - OF for ifun 0 (add): a[msb]==b[msb] && r[msb]!=a[msb].
  - OF for ifun 1 (sub, B-A): a[msb]!=b[msb] && r[msb]!=b[msb].
  - OF for ifun 2/3 (and/xor): 0.
  - OF for ifun >3: CC unchanged.
  - OF is computed locally; the ALU's carry-out is ignored.
- Cnd is combinational from the CC values before this instruction's own update, then registered:
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): !ZF
  - ifun 5 (ge): !(SF^OF)
  - ifun 6 (g): !(SF^OF)&&!ZF
  - ifun >6: 0
- Back-to-back: an OPq accepted in cycle n updates CC at edge n+1. A jXX accepted in cycle n+1 sees the new CC.
- dstE squash: if in_icode==2 and Cnd==0, out_dstE=RNONE; otherwise out_dstE=in_dstE.
- out_valE = in_alu_result for all icodes. out_cnd is 0 for icodes other than 2 and 7.
- Reset mid-operation: a pending unaccepted output is lost and CC returns to its reset values.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: I_RRMOVQ=2, I_OPQ=6, I_JXX=7.
  - ALU function constants: ADD=0, SUB=1, AND=2, XOR=3.
  - Condition constants C_*.
  - RNONE.
- One natural sub-module, cond_eval: combinational (ZF, SF, OF, ifun) -> cnd. It is reused by the decode-stage branch predictor check.

Test Plan:
- Reset: pulse rst asynchronously mid-cycle -> ZF=1, SF=0, OF=0, out_valid=0, out_dstE=F immediately, without waiting for an edge.
- Sub overflow: OPq ifun 1, a=1, b=0x8000_0000_0000_0000, result=0x7FFF_FFFF_FFFF_FFFF -> next cycle OF=1, SF=0, ZF=0.
- Compare then branch: OPq sub with a=5, b=5, result=0 -> ZF=1; next cycle jXX ifun 3 -> out_cnd=1; jXX ifun 4 -> out_cnd=0.
- cmov not taken: with SF=0, OF=0, issue icode 2, ifun 2 (l), dstE=3 -> out_dstE=F and out_valE=result.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, CC updated once only; raise out_ready -> next payload accepted.
- Flush and inhibit:
  - flush with an accepted OPq -> out_valid=0, CC unchanged.
  - cc_inhibit=1 with OPq result=0 -> ZF keeps its prior value.
